// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register access arbiter.
// Imported by the picker and the arbiter top.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    DONE
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/reg_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or above ptr, wrapping modulo NREQ.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int PW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);

  logic          found;
  int            j;
  logic [PW-1:0] jj;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (!found && req[jj]) begin
        found   = 1'b1;
        win[jj] = 1'b1;
        win_idx = jj;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter serialising write-with-readback and
// read-only accesses from NREQ masters to one shared register.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [WIDTH-1:0]      rdata,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    w_q, w_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic [NREQ-1:0]  pick_win;
  logic [PW-1:0]    pick_idx;
  logic [WIDTH-1:0] wsel;
  logic [PW-1:0]    ptr_nxt;
  logic             hit;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  assign wsel    = wdata[int'(w_q)*WIDTH +: WIDTH];
  assign hit     = req[w_q];
  assign ptr_nxt = (w_q == PW'(NREQ-1)) ? '0 : w_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = SERVE;
      SERVE:   state_d = hit ? DONE : IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A dropped req during SERVE is an abort: ptr still advances.
  always_comb begin
    gnt_d   = '0;
    ack_d   = 1'b0;
    w_d     = w_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    q_d     = q_q;
    busy_d  = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        gnt_d = pick_win;
        if (|req) w_d = pick_idx;
      end
      SERVE: begin
        ptr_d = ptr_nxt;
        if (hit) begin
          ack_d   = 1'b1;
          rdata_d = q_q;
          if (we[w_q]) q_d = wsel;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q   <= '0;
      w_q     <= '0;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      q_q     <= '0;
    end else begin
      ptr_q   <= ptr_d;
      w_q     <= w_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      q_q     <= q_d;
    end
  end

  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;
  assign q     = q_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: model predicts
// winner order, readback and register value per access.
module tb_reg_access_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   we    = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic           ack;
  logic [W-1:0]   rdata;
  logic [W-1:0]   q;
  logic           busy;

  reg_access_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .we    (we),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .rdata (rdata),
    .q     (q),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rd;
    logic [W-1:0] qv;
  } exp_t;

  exp_t         sb[$];
  exp_t         pe;
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] mq    = '0;
  int           mptr  = 0;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      int j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) chk("ack_unexpected", ack, 0);
      else begin
        pe = sb.pop_front();
        chk("rdata", rdata, pe.rd);
        chk("q_after", q, pe.qv);
      end
    end
  end

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic contend(logic [N-1:0] rv, logic [N-1:0] wv,
                         int ng, bit rearm);
    logic [N-1:0] pend;
    logic [W-1:0] nq;
    int t0, tl, e;
    bit ok;
    pend = rv;
    req  = rv;
    we   = wv;
    t0   = cyc;
    tl   = cyc;
    for (int n = 0; n < ng; n++) begin
      wait_gnt(ok);
      chk("gnt_seen", ok, 1);
      if (!ok) begin
        req = '0;
        return;
      end
      e = pick(pend, mptr);
      chk("gnt_onehot", gnt, 1 << e);
      if (n == 0) chk("gnt_lat", cyc - t0, 1);
      else        chk("gnt_gap", cyc - tl, 3);
      tl = cyc;
      chk("busy_serve", busy, 1);
      chk("ack_serve", ack, 0);
      nq = we[e] ? wdata[e*W +: W] : mq;
      sb.push_back('{mq, nq});
      mq   = nq;
      mptr = (e + 1) % N;
      @(negedge clk);
      chk("ack_done", ack, 1);
      chk("gnt_done", gnt, 0);
      pend[e] = 1'b0;
      req = (n == ng - 1) ? '0 : pend;
      if (rearm && n != ng - 1) begin
        @(negedge clk);
        pend[e] = 1'b1;
        req = pend;
      end
    end
    @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b1;
    @(negedge clk);

    wdata[7:0] = 8'h0F;
    contend(4'b0001, 4'b0001, 1, 0);
    chk("q_hold_w0", q, 8'h0F);

    contend(4'b0100, 4'b0000, 1, 0);
    chk("q_hold_rd", q, 8'h0F);

    wdata[31:24] = 8'h33;
    contend(4'b1000, 4'b1000, 1, 0);

    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    contend(4'b1111, 4'b1111, 5, 1);

    wdata[15:8] = 8'hAA;
    req = 4'b0010;
    we  = 4'b0010;
    @(negedge clk);
    chk("abort_gnt", gnt, 4'b0010);
    req = '0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_gnt0", gnt, 0);
    chk("abort_q", q, mq);
    mptr = 2;
    @(negedge clk);
    chk("abort_ack", ack, 0);

    wdata[23:16] = 8'hC2;
    wdata[15:8]  = 8'hB1;
    contend(4'b0110, 4'b0110, 2, 0);
    contend(4'b0100, 4'b0000, 1, 0);

    wdata[31:24] = 8'hD3;
    wdata[7:0]   = 8'hE0;
    contend(4'b1001, 4'b1001, 2, 0);

    wdata[23:16] = 8'h55;
    req = 4'b0100;
    we  = 4'b0100;
    @(negedge clk);
    chk("rst_srv_gnt", gnt, 4'b0100);
    reset = 1'b0;
    #1;
    chk("rst_mid_q", q, 0);
    chk("rst_mid_gnt", gnt, 0);
    chk("rst_mid_ack", ack, 0);
    chk("rst_mid_busy", busy, 0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mq   = '0;
    mptr = 0;
    repeat (4) @(negedge clk);
    chk("rst_post_q", q, 0);
    chk("rst_post_ack", ack, 0);

    wdata[7:0]  = 8'h5A;
    wdata[15:8] = 8'hA5;
    contend(4'b0011, 4'b0011, 2, 0);
    chk("final_q", q, 8'hA5);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
